rr_mem_arbiter: RTL and testbench

RR_MEM_ARBITER -- requirements
Module: rr_mem_arbiter

---
 rtl/rr_mem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_rr_mem_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_mem_arbiter.sv
// Round-robin arbiter that funnels N_PORTS single-beat memory requests onto one
// downstream bus, with an optional wait timeout that completes the request with an error.
module rr_mem_arbiter #(
  parameter int N_PORTS = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  localparam int STRB_W    = DATA_W / 8,
  localparam int PORT_BITS = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [N_PORTS-1:0]          req_valid,
  input  logic [N_PORTS*ADDR_W-1:0]   req_addr,
  input  logic [N_PORTS*DATA_W-1:0]   req_wdata,
  input  logic [N_PORTS*STRB_W-1:0]   req_wstrb,
  output logic [N_PORTS-1:0]          req_ack,
  output logic [N_PORTS-1:0]          req_err,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        bus_valid,
  output logic [ADDR_W-1:0]           bus_addr,
  output logic [DATA_W-1:0]           bus_wdata,
  output logic [STRB_W-1:0]           bus_wstrb,
  input  logic                        bus_ready,
  input  logic [DATA_W-1:0]           bus_rdata,
  output logic [PORT_BITS-1:0]        grant_id,
  output logic                        busy,
  output logic [1:0]                  dbg_state
);

  // Handshake: a port holds req_valid (and its fields) until it sees its one-cycle
  // req_ack; downstream, bus_valid and bus_* stay constant until a one-cycle bus_ready.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  logic [1:0]           r_state;
  logic [PORT_BITS-1:0] r_last;
  logic [PORT_BITS-1:0] r_grant;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_bus_valid;
  logic [ADDR_W-1:0]    r_bus_addr;
  logic [DATA_W-1:0]    r_bus_wdata;
  logic [STRB_W-1:0]    r_bus_wstrb;
  logic [DATA_W-1:0]    r_rdata;
  logic [N_PORTS-1:0]   r_ack;
  logic [N_PORTS-1:0]   r_err;

  logic                 w_found;
  logic [PORT_BITS-1:0] w_sel;
  int                   w_idx;
  logic [N_PORTS-1:0]   w_shift;
  logic [ADDR_W-1:0]    w_addr;
  logic [DATA_W-1:0]    w_wdata;
  logic [STRB_W-1:0]    w_wstrb;
  logic [N_PORTS-1:0]   w_grant_oh;
  logic                 w_timeout;

  // Scan starts one past the last served port so every requester is reached within N_PORTS grants.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = 0;
    w_shift = '0;
    for (int i = 1; i <= N_PORTS; i++) begin
      w_idx = int'(r_last) + i;
      if (w_idx >= N_PORTS) w_idx = w_idx - N_PORTS;
      w_shift = req_valid >> w_idx;
      if (!w_found && w_shift[0]) begin
        w_found = 1'b1;
        w_sel   = PORT_BITS'(w_idx);
      end
    end
  end

  always_comb begin
    w_addr  = '0;
    w_wdata = '0;
    w_wstrb = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (w_sel == PORT_BITS'(p)) begin
        w_addr  = req_addr[p*ADDR_W +: ADDR_W];
        w_wdata = req_wdata[p*DATA_W +: DATA_W];
        w_wstrb = req_wstrb[p*STRB_W +: STRB_W];
      end
    end
  end

  always_comb begin
    w_grant_oh = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      w_grant_oh[p] = (r_grant == PORT_BITS'(p));
    end
  end

  assign w_timeout = (TIMEOUT != 0) && (r_cnt == TO_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_last      <= PORT_BITS'(N_PORTS - 1);
      r_grant     <= '0;
      r_cnt       <= '0;
      r_bus_valid <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_wstrb <= '0;
      r_rdata     <= '0;
      r_ack       <= '0;
      r_err       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_bus_valid <= 1'b1;
            r_bus_addr  <= w_addr;
            r_bus_wdata <= w_wdata;
            r_bus_wstrb <= w_wstrb;
            r_grant     <= w_sel;
            r_cnt       <= '0;
            r_state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          // bus_ready takes priority over a coincident timeout.
          if (bus_ready) begin
            r_bus_valid <= 1'b0;
            r_rdata     <= bus_rdata;
            r_ack       <= w_grant_oh;
            r_last      <= r_grant;
            r_state     <= S_ACK;
          end else if (w_timeout) begin
            r_bus_valid <= 1'b0;
            r_rdata     <= '0;
            r_ack       <= w_grant_oh;
            r_err       <= w_grant_oh;
            r_last      <= r_grant;
            r_state     <= S_ACK;
          end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_ACK: begin
          r_ack   <= '0;
          r_err   <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ack   = r_ack;
  assign req_err   = r_err;
  assign rsp_rdata = r_rdata;
  assign bus_valid = r_bus_valid;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign bus_wstrb = r_bus_wstrb;
  assign grant_id  = r_grant;
  assign busy      = (r_state != S_IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_rr_mem_arbiter.sv
// Directed bench for rr_mem_arbiter: a 4-port build with TIMEOUT=8 and a 1-port build
// share clock and reset; each step checks outputs against hand-computed values.
module tb_rr_mem_arbiter;

  logic         clk;
  logic         resetn;

  logic [3:0]   req_valid;
  logic [127:0] req_addr;
  logic [127:0] req_wdata;
  logic [15:0]  req_wstrb;
  logic [3:0]   req_ack;
  logic [3:0]   req_err;
  logic [31:0]  rsp_rdata;
  logic         bus_valid;
  logic [31:0]  bus_addr;
  logic [31:0]  bus_wdata;
  logic [3:0]   bus_wstrb;
  logic         bus_ready;
  logic [31:0]  bus_rdata;
  logic [1:0]   grant_id;
  logic         busy;
  logic [1:0]   dbg_state;

  logic         s_req_valid;
  logic [31:0]  s_req_addr;
  logic [31:0]  s_req_wdata;
  logic [3:0]   s_req_wstrb;
  logic         s_req_ack;
  logic         s_req_err;
  logic [31:0]  s_rsp_rdata;
  logic         s_bus_valid;
  logic [31:0]  s_bus_addr;
  logic [31:0]  s_bus_wdata;
  logic [3:0]   s_bus_wstrb;
  logic         s_bus_ready;
  logic [31:0]  s_bus_rdata;
  logic         s_grant_id;
  logic         s_busy;
  logic [1:0]   s_dbg_state;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int prev_cyc = 0;
  int exp_p;

  rr_mem_arbiter #(.N_PORTS(4), .ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) u_dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .req_ack(req_ack), .req_err(req_err), .rsp_rdata(rsp_rdata),
    .bus_valid(bus_valid), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata),
    .grant_id(grant_id), .busy(busy), .dbg_state(dbg_state)
  );

  rr_mem_arbiter #(.N_PORTS(1), .ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) u_dut1 (
    .clk(clk), .resetn(resetn),
    .req_valid(s_req_valid), .req_addr(s_req_addr), .req_wdata(s_req_wdata), .req_wstrb(s_req_wstrb),
    .req_ack(s_req_ack), .req_err(s_req_err), .rsp_rdata(s_rsp_rdata),
    .bus_valid(s_bus_valid), .bus_addr(s_bus_addr), .bus_wdata(s_bus_wdata), .bus_wstrb(s_bus_wstrb),
    .bus_ready(s_bus_ready), .bus_rdata(s_bus_rdata),
    .grant_id(s_grant_id), .busy(s_busy), .dbg_state(s_dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    resetn      = 1'b0;
    req_valid   = '0;
    req_addr    = '0;
    req_wdata   = '0;
    req_wstrb   = '0;
    bus_ready   = 1'b0;
    bus_rdata   = '0;
    s_req_valid = 1'b0;
    s_req_addr  = '0;
    s_req_wdata = '0;
    s_req_wstrb = '0;
    s_bus_ready = 1'b0;
    s_bus_rdata = '0;

    step();
    step();
    chk("rst_bus_valid", 64'(bus_valid), 64'd0);
    chk("rst_req_ack",   64'(req_ack),   64'd0);
    chk("rst_req_err",   64'(req_err),   64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_grant_id",  64'(grant_id),  64'd0);
    chk("rst_bus_addr",  64'(bus_addr),  64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_state",     64'(dbg_state), 64'd0);

    for (int p = 0; p < 4; p++) begin
      req_addr[p*32 +: 32]  = 32'h1000 + 32'(p * 16);
      req_wdata[p*32 +: 32] = 32'hD0 + 32'(p);
      req_wstrb[p*4 +: 4]   = 4'h0;
    end

    // Single read from port 2, first grant on the first edge after reset release
    resetn = 1'b1;
    req_addr[2*32 +: 32] = 32'h100;
    req_valid = 4'b0100;
    step();
    chk("rd_bus_valid", 64'(bus_valid), 64'd1);
    chk("rd_grant_id",  64'(grant_id),  64'd2);
    chk("rd_bus_addr",  64'(bus_addr),  64'h100);
    chk("rd_bus_wstrb", 64'(bus_wstrb), 64'h0);
    chk("rd_busy",      64'(busy),      64'd1);
    chk("rd_state",     64'(dbg_state), 64'd1);
    step();
    step();
    chk("rd_hold_valid", 64'(bus_valid), 64'd1);
    chk("rd_hold_addr",  64'(bus_addr),  64'h100);
    chk("rd_no_ack",     64'(req_ack),   64'd0);
    bus_ready = 1'b1;
    bus_rdata = 32'hCAFEF00D;
    step();
    chk("rd_req_ack",   64'(req_ack),   64'b0100);
    chk("rd_req_err",   64'(req_err),   64'd0);
    chk("rd_rsp_rdata", 64'(rsp_rdata), 64'hCAFEF00D);
    chk("rd_bus_idle",  64'(bus_valid), 64'd0);
    chk("rd_state_ack", 64'(dbg_state), 64'd2);
    bus_ready = 1'b0;
    bus_rdata = 32'h0;
    req_valid = 4'b0000;
    step();
    chk("rd_ack_clr",   64'(req_ack),   64'd0);
    chk("rd_busy_clr",  64'(busy),      64'd0);
    chk("rd_rdata_hold", 64'(rsp_rdata), 64'hCAFEF00D);

    // Reset in the middle of a port-3 wait
    req_addr[2*32 +: 32] = 32'h1020;
    req_valid = 4'b1000;
    step();
    chk("mr_grant_id",  64'(grant_id),  64'd3);
    chk("mr_bus_valid", 64'(bus_valid), 64'd1);
    step();
    #2;
    resetn = 1'b0;
    #1;
    chk("mr_async_valid", 64'(bus_valid), 64'd0);
    chk("mr_async_busy",  64'(busy),      64'd0);
    chk("mr_async_ack",   64'(req_ack),   64'd0);
    chk("mr_async_grant", 64'(grant_id),  64'd0);
    req_valid = 4'b1111;
    step();
    chk("mr_no_ack", 64'(req_ack), 64'd0);
    resetn = 1'b1;

    // All four ports requesting: order 0,1,2,3,0 with 4-cycle spacing
    for (int k = 0; k < 5; k++) begin
      exp_p = k % 4;
      step();
      chk("rr_grant_id",  64'(grant_id),  64'(exp_p));
      chk("rr_bus_addr",  64'(bus_addr),  64'(32'h1000 + 32'(exp_p * 16)));
      chk("rr_bus_wdata", 64'(bus_wdata), 64'(32'hD0 + 32'(exp_p)));
      chk("rr_bus_valid", 64'(bus_valid), 64'd1);
      if (k > 0) chk("rr_spacing", 64'(cyc - prev_cyc), 64'd4);
      prev_cyc = cyc;
      step();
      bus_ready = 1'b1;
      bus_rdata = 32'hA000 + 32'(k);
      step();
      chk("rr_req_ack",   64'(req_ack),   64'(4'b0001 << exp_p));
      chk("rr_req_err",   64'(req_err),   64'd0);
      chk("rr_rsp_rdata", 64'(rsp_rdata), 64'(32'hA000 + 32'(k)));
      chk("rr_bus_idle",  64'(bus_valid), 64'd0);
      bus_ready = 1'b0;
      step();
      chk("rr_idle_busy", 64'(busy), 64'd0);
    end
    req_valid = 4'b0000;

    // Port 1 write that never sees bus_ready; port drops req_valid mid-wait
    req_wstrb[1*4 +: 4] = 4'hF;
    bus_rdata = 32'hDEADBEEF;
    req_valid = 4'b0010;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("to_bus_valid", 64'(bus_valid), 64'd1);
      chk("to_no_ack",    64'(req_ack),   64'd0);
      if (i == 0) begin
        chk("to_grant_id",  64'(grant_id),  64'd1);
        chk("to_bus_wstrb", 64'(bus_wstrb), 64'hF);
      end
      if (i == 3) req_valid = 4'b0000;
    end
    step();
    chk("to_req_ack",   64'(req_ack),   64'b0010);
    chk("to_req_err",   64'(req_err),   64'b0010);
    chk("to_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("to_bus_idle",  64'(bus_valid), 64'd0);
    step();
    chk("to_err_clr", 64'(req_err), 64'd0);
    chk("to_ack_clr", 64'(req_ack), 64'd0);
    bus_rdata = 32'h0;

    // bus_ready on the exact timeout cycle: completes normally
    req_valid = 4'b0100;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("co_bus_valid", 64'(bus_valid), 64'd1);
      if (i == 0) chk("co_grant_id", 64'(grant_id), 64'd2);
      if (i == 7) begin
        bus_ready = 1'b1;
        bus_rdata = 32'h5A5A1234;
      end
    end
    step();
    chk("co_req_ack",   64'(req_ack),   64'b0100);
    chk("co_req_err",   64'(req_err),   64'd0);
    chk("co_rsp_rdata", 64'(rsp_rdata), 64'h5A5A1234);
    bus_ready = 1'b0;
    req_valid = 4'b0000;
    step();

    // Stray bus_ready while idle is ignored
    bus_ready = 1'b1;
    bus_rdata = 32'h11112222;
    step();
    chk("ig_req_ack",   64'(req_ack),   64'd0);
    chk("ig_busy",      64'(busy),      64'd0);
    chk("ig_rsp_rdata", 64'(rsp_rdata), 64'h5A5A1234);
    bus_ready = 1'b0;
    step();
    chk("ig_req_ack2", 64'(req_ack), 64'd0);

    // Single-port build: back-to-back requests
    s_req_addr  = 32'h2000;
    s_req_wdata = 32'h12345678;
    s_req_wstrb = 4'h3;
    s_req_valid = 1'b1;
    for (int t = 0; t < 2; t++) begin
      step();
      chk("sp_bus_valid", 64'(s_bus_valid), 64'd1);
      chk("sp_grant_id",  64'(s_grant_id),  64'd0);
      chk("sp_bus_addr",  64'(s_bus_addr),  64'(32'h2000 + 32'(t * 4)));
      chk("sp_bus_wstrb", 64'(s_bus_wstrb), 64'h3);
      step();
      s_bus_ready = 1'b1;
      s_bus_rdata = 32'h77770000 + 32'(t);
      step();
      chk("sp_req_ack",   64'(s_req_ack),   64'd1);
      chk("sp_req_err",   64'(s_req_err),   64'd0);
      chk("sp_rsp_rdata", 64'(s_rsp_rdata), 64'(32'h77770000 + 32'(t)));
      s_bus_ready = 1'b0;
      s_req_addr  = 32'h2004;
      if (t == 1) s_req_valid = 1'b0;
      step();
      chk("sp_busy_clr", 64'(s_busy), 64'd0);
    end
    step();
    chk("sp_end_valid", 64'(s_bus_valid), 64'd0);
    chk("sp_end_grant", 64'(s_grant_id),  64'd0);
    chk("sp_end_ack",   64'(s_req_ack),   64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
